// File: rtl/serial_recv_if.sv
// Serial receiver port bundle: serial line in, received byte and status strobes out.
interface serial_recv_if;
  logic       DATA_IN;
  logic [7:0] DATA_OUT;
  logic       VALID;
  logic       FERR;
  logic       BUSY;

  modport master (
    output DATA_IN,
    input  DATA_OUT,
    input  VALID,
    input  FERR,
    input  BUSY
  );

  modport slave (
    input  DATA_IN,
    output DATA_OUT,
    output VALID,
    output FERR,
    output BUSY
  );
endinterface

// File: rtl/serial_recv.sv
// 8N1 UART receiver, LSB first, WAIT_DIV clocks per bit.
// Optional macro SERIAL_RECV_GLITCH_FILTER_EN: every sample point takes a
// 2-of-3 majority of rx_s over the last three cycles instead of one sample.
module serial_recv #(
  parameter int unsigned WAIT_DIV = 868
) (
  input logic         CLK,
  input logic         RST_N,
  serial_recv_if.slave bus
);

  localparam int unsigned HALF_DIV = WAIT_DIV / 2;
  localparam int unsigned WAIT_LEN = $clog2(WAIT_DIV);
  localparam logic [WAIT_LEN-1:0] HALF_LAST = WAIT_LEN'(HALF_DIV - 1);
  localparam logic [WAIT_LEN-1:0] BIT_LAST  = WAIT_LEN'(WAIT_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_LEN-1:0] timer_q, timer_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic [7:0]          data_q, data_d;
  logic                valid_q, valid_d;
  logic                ferr_q, ferr_d;
  logic [1:0]          sync_q, sync_d;
  logic                rx_s;
  logic                sample;

  assign rx_s = sync_q[1];

  // Two-flop synchroniser for the asynchronous serial line
  always_comb sync_d = {sync_q[0], bus.DATA_IN};

  // Synchroniser register, idles high
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) sync_q <= '1;
    else        sync_q <= sync_d;
  end

`ifdef SERIAL_RECV_GLITCH_FILTER_EN
  logic [1:0] hist_q, hist_d;

  // History of rx_s for the two cycles before the current one
  always_comb hist_d = {hist_q[0], rx_s};

  // History register, idles high like the line
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) hist_q <= '1;
    else        hist_q <= hist_d;
  end

  // Majority of rx_s at S-2, S-1 and S; decision still taken at S
  always_comb sample = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  // Single sample of rx_s at the sample point
  always_comb sample = rx_s;
`endif

  // Frame FSM: next state, bit timer, shift register and strobes
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (timer_q == HALF_LAST) begin
          timer_d = '0;
          if (!sample) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q + WAIT_LEN'(1);
        end
      end
      ST_DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d   = '0;
          shift_d   = {sample, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_STOP;
        end else begin
          timer_d = timer_q + WAIT_LEN'(1);
        end
      end
      ST_STOP: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          if (sample) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end else begin
          timer_d = timer_q + WAIT_LEN'(1);
        end
      end
      ST_BREAK: begin
        timer_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Frame state registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign bus.DATA_OUT = data_q;
  assign bus.VALID    = valid_q;
  assign bus.FERR     = ferr_q;
  assign bus.BUSY     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_recv.sv
// Scoreboard bench for serial_recv at WAIT_DIV=16: the stimulus side queues
// the expected outcome of each frame, a monitor pops it on VALID/FERR.
module tb_serial_recv;

  localparam int WD = 16;

  typedef struct packed {
    logic       ferr;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic RST_N;
  serial_recv_if bus ();

  serial_recv #(.WAIT_DIV(WD)) dut (
    .CLK   (clk),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  exp_t exp_q[$];
  int valid_times[$];
  logic [7:0] exp_last = 8'h00;
  logic busy_chk_pending = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: outputs change only at posedge, so sample at negedge
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (RST_N) begin
      if (busy_chk_pending) begin
        chk("busy_after_valid", 32'(bus.BUSY), 32'd0);
        busy_chk_pending = 1'b0;
      end
      if (bus.VALID || bus.FERR) begin
        if (bus.VALID && bus.FERR) begin
          chk("valid_ferr_exclusive", 32'd1, 32'd0);
        end else if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {bus.FERR, bus.VALID}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          if (bus.VALID) begin
            valid_times.push_back(cyc);
            chk("strobe_kind_valid", 32'(e.ferr), 32'd0);
            chk("data_out", 32'(bus.DATA_OUT), 32'(e.data));
            exp_last = e.data;
            busy_chk_pending = 1'b1;
          end else begin
            chk("strobe_kind_ferr", 32'(e.ferr), 32'd1);
            chk("ferr_data_hold", 32'(bus.DATA_OUT), 32'(exp_last));
          end
        end
      end
    end
  end

  // Hard time limit so the run always ends
  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.DATA_IN = 1'b1;
    end
  endtask

  task automatic hold_low(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.DATA_IN = 1'b0;
    end
  endtask

  // Drive one frame; glitch_c forces the line high for that one cycle,
  // stop_at >= 0 abandons the frame at that cycle
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int glitch_c, input int stop_at);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int c = 0; c < 10 * WD; c++) begin
      if (c == stop_at) return;
      @(negedge clk);
      bus.DATA_IN = fr[c / WD];
      if (c == glitch_c) bus.DATA_IN = 1'b1;
    end
  endtask

  task automatic push_good(input logic [7:0] b);
    exp_t e;
    e.ferr = 1'b0;
    e.data = b;
    exp_q.push_back(e);
  endtask

  task automatic push_ferr();
    exp_t e;
    e.ferr = 1'b1;
    e.data = 8'h00;
    exp_q.push_back(e);
  endtask

  initial begin
    int diff;
    logic [7:0] rb;
    logic       rstop;
    logic [7:0] glitch_exp;

    RST_N = 1'b0;
    bus.DATA_IN = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data_out", 32'(bus.DATA_OUT), 32'h00);
    chk("rst_valid", 32'(bus.VALID), 32'd0);
    chk("rst_ferr", 32'(bus.FERR), 32'd0);
    chk("rst_busy", 32'(bus.BUSY), 32'd0);
    RST_N = 1'b1;
    idle(5);

    // Single good frame
    push_good(8'h55);
    send_frame(8'h55, 1'b1, -1, -1);
    idle(10);

    // Back-to-back frames with no idle gap
    valid_times.delete();
    push_good(8'h00);
    send_frame(8'h00, 1'b1, -1, -1);
    push_good(8'hFF);
    send_frame(8'hFF, 1'b1, -1, -1);
    idle(20);
    chk("b2b_valid_count", 32'(valid_times.size()), 32'd2);
    if (valid_times.size() == 2) begin
      diff = valid_times[1] - valid_times[0];
      chk("b2b_gap_in_range", 32'(diff >= 158 && diff <= 162), 32'd1);
    end

    // Framing error, line held low, then recovery
    push_ferr();
    send_frame(8'hA3, 1'b0, -1, -1);
    hold_low(40);
    chk("break_busy", 32'(bus.BUSY), 32'd1);
    idle(10);
    chk("break_released", 32'(bus.BUSY), 32'd0);
    push_good(8'h3C);
    send_frame(8'h3C, 1'b1, -1, -1);
    idle(10);

    // Short low pulse: false start
    hold_low(3);
    @(negedge clk);
    chk("false_start_busy", 32'(bus.BUSY), 32'd1);
    bus.DATA_IN = 1'b1;
    idle(WD / 2 + 3);
    chk("false_start_idle", 32'(bus.BUSY), 32'd0);
    idle(5);

    // Reset in the middle of data bit 4
    send_frame(8'h96, 1'b1, -1, WD * 5 + 8);
    #2;
    RST_N = 1'b0;
    #1;
    exp_last = 8'h00;
    chk("midrst_data_out", 32'(bus.DATA_OUT), 32'h00);
    chk("midrst_valid", 32'(bus.VALID), 32'd0);
    chk("midrst_ferr", 32'(bus.FERR), 32'd0);
    chk("midrst_busy", 32'(bus.BUSY), 32'd0);
    bus.DATA_IN = 1'b1;
    repeat (3) @(negedge clk);
    RST_N = 1'b1;
    idle(5);
    push_good(8'h96);
    send_frame(8'h96, 1'b1, -1, -1);
    idle(10);

    // One-cycle high spike at the centre of data bit 3 of 8'h00
`ifdef SERIAL_RECV_GLITCH_FILTER_EN
    glitch_exp = 8'h00;
`else
    glitch_exp = 8'h08;
`endif
    push_good(glitch_exp);
    send_frame(8'h00, 1'b1, WD * 4 + WD / 2, -1);
    idle(10);

    // Random frames, some with a bad stop bit
    for (int i = 0; i < 12; i++) begin
      rb = 8'($urandom);
      rstop = ($urandom_range(0, 4) != 0);
      if (rstop) push_good(rb);
      else       push_ferr();
      send_frame(rb, rstop, -1, -1);
      if (rstop) idle($urandom_range(0, 20));
      else       idle($urandom_range(4, 20));
    end

    idle(40);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
